alu_cmd_master: RTL
===================

// Module: alu_cmd_master
// PURPOSE
//  Host-side command initiator for the UART ALU link: the far end of the serial protocol that the ALU board answers.
//  Takes one ALU request (op A, op B, opcode), pushes it as three bytes into its local uart_core TX FIFO,
//  then pops the one-byte result from the RX FIFO, or flags a timeout if no byte arrives in time.
//  Sits between a test/host controller and a uart_core instance; used for board-to-board loopback and system benches.
// PARAMETERS
//  NB_DATA        8       data/byte width; matches uart_core NB_DATA
//  NB_OPCODE      6       ALU opcode width (NB_OPCODE <= NB_DATA)
//  TIMEOUT_CYCLES 300000  max clk cycles spent in WAIT_RES before timeout (>= 2)
//  NB_TIMEOUT     19      timeout counter width; must hold TIMEOUT_CYCLES-1
// PORTS
//  i_clk            in   1          system clock
//  i_reset          in   1          asynchronous, active-low reset
//  i_start          in   1          request strobe; accepted only in IDLE
//  i_op_A           in   NB_DATA    operand A, sampled on accept
//  i_op_B           in   NB_DATA    operand B, sampled on accept
//  i_opcode         in   NB_OPCODE  ALU opcode, sampled on accept
//  o_busy           out  1          1 in every state except IDLE
//  o_done           out  1          1-cycle pulse: transaction finished (result or timeout)
//  o_result         out  NB_DATA    last result byte received
//  o_timeout        out  1          1 = last transaction ended by timeout
//  i_fifo_tx_full   in   1          uart_core TX FIFO full
//  o_fifo_tx_write  out  1          TX FIFO push strobe
//  o_data_to_write  out  NB_DATA    byte pushed with o_fifo_tx_write
//  i_fifo_rx_empty  in   1          uart_core RX FIFO empty
//  i_data_to_read   in   NB_DATA    RX FIFO head (valid whenever !i_fifo_rx_empty, show-ahead)
//  o_fifo_rx_read   out  1          RX FIFO pop strobe
// BEHAVIOUR
//  Reset (i_reset=0, async): state IDLE; o_busy, o_done, o_timeout, o_fifo_tx_write, o_fifo_rx_read = 0;
//   o_result, o_data_to_write, operand regs, timeout counter = 0. Reset mid-transaction abandons it, no o_done.
//  States: IDLE -> SEND_A -> SEND_B -> SEND_OP -> WAIT_RES -> DONE -> IDLE.
//  IDLE: i_start=1 -> latch A, B, opcode; clear o_timeout; go SEND_A next cycle.
//   If !i_fifo_rx_empty in IDLE: pop (o_fifo_rx_read=1) and discard stale byte, one per cycle.
//   i_start and a stale pop in the same cycle: both happen.
//  SEND_x: o_fifo_tx_write = !i_fifo_tx_full (combinational); o_data_to_write = A / B / {zero-ext opcode}.
//   Advance only on a cycle where the write is asserted; while full, hold state, no write. Never write when full.
//  Wire order fixed: byte0 = A, byte1 = B, byte2 = opcode zero-extended to NB_DATA.
//  WAIT_RES: counter cleared on entry, +1 per cycle. If !i_fifo_rx_empty: o_fifo_rx_read=1 same cycle,
//   o_result <= i_data_to_read, go DONE. Else if counter == TIMEOUT_CYCLES-1: o_timeout <= 1, go DONE,
//   o_result unchanged. Byte present on the expiry cycle wins (no timeout).
//  DONE: o_done=1 for exactly this cycle, o_busy=1; next cycle IDLE.
//  Latency, no back-pressure: accept at cycle 0; writes at cycles 1,2,3; WAIT_RES from 4;
//   byte visible at cycle N -> pop at N, o_done at N+1, o_busy low at N+2.
//  i_start while o_busy=1: ignored, no queueing. Inputs A/B/opcode may change after accept.
//  Late reply (after timeout) is discarded by the IDLE stale-drain, never reported as a result.
// TESTING
//  1) Reset, A=0x05 B=0x03 op=0x20, FIFOs never full, reply 0x08 at cycle 10 -> writes 05,03,20 on cycles 1-3; pop at 10; o_done@11, o_result=08, o_timeout=0.
//  2) i_fifo_tx_full=1 cycles 2-5 -> B write stalls; exactly 3 writes total, order 05,03,20, none while full.
//  3) TIMEOUT_CYCLES=16, no reply -> o_done 16 cycles after WAIT_RES entry, o_timeout=1, o_result keeps previous value.
//  4) Reply arrives on counter expiry cycle -> result taken, o_timeout=0; late byte after timeout -> popped in IDLE, no o_done.
//  5) i_start pulsed while busy with A=0xFF -> ignored; outputs of original transaction unchanged.
//  6) i_reset low during SEND_B (async, mid-cycle) -> all outputs 0 immediately, IDLE, no further writes, no o_done.

Source files
------------

// File: rtl/alu_cmd_master.sv
// Purpose: host-side initiator for the UART ALU link. It sends A, B and the opcode as three bytes, then collects the one-byte result.
// Latency: start accepted at cycle 0, bytes pushed at cycles 1-3, WAIT_RES from cycle 4. A reply visible at cycle N gives o_done at N+1.
// Backpressure: each byte is held while the TX FIFO is full. i_start is ignored while busy, and nothing is queued.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   host side : i_start, i_op_A, i_op_B, i_opcode -> o_busy, o_done, o_result, o_timeout
//   uart_core : i_fifo_tx_full, o_fifo_tx_write, o_data_to_write,
//               i_fifo_rx_empty, i_data_to_read, o_fifo_rx_read
module alu_cmd_master #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 300000,
    parameter int NB_TIMEOUT     = 19
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_DATA-1:0]   i_op_A,
    input  logic [NB_DATA-1:0]   i_op_B,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_timeout,
    input  logic                 i_fifo_tx_full,
    output logic                 o_fifo_tx_write,
    output logic [NB_DATA-1:0]   o_data_to_write,
    input  logic                 i_fifo_rx_empty,
    input  logic [NB_DATA-1:0]   i_data_to_read,
    output logic                 o_fifo_rx_read
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_SEND_B   = 3'd2,
        ST_SEND_OP  = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_n;
    logic [NB_DATA-1:0]     op_a_q, op_b_q;
    logic [NB_OPCODE-1:0]   opcode_q;
    logic [NB_TIMEOUT-1:0]  cnt_q;

    logic                   accept;
    logic                   take_res;
    logic                   expire;
    logic                   rx_read_raw;

    // Next-state and strobe decode
    always_comb begin
        state_n         = state;
        accept          = 1'b0;
        take_res        = 1'b0;
        expire          = 1'b0;
        rx_read_raw     = 1'b0;
        o_fifo_tx_write = 1'b0;
        o_data_to_write = '0;

        case (state)
            ST_IDLE: begin
                // Drain any stale byte, such as a reply that arrived after a timeout.
                rx_read_raw = !i_fifo_rx_empty;
                if (i_start) begin
                    accept  = 1'b1;
                    state_n = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                o_data_to_write = op_a_q;
                o_fifo_tx_write = !i_fifo_tx_full;
                if (!i_fifo_tx_full) state_n = ST_SEND_B;
            end
            ST_SEND_B: begin
                o_data_to_write = op_b_q;
                o_fifo_tx_write = !i_fifo_tx_full;
                if (!i_fifo_tx_full) state_n = ST_SEND_OP;
            end
            ST_SEND_OP: begin
                o_data_to_write = NB_DATA'(opcode_q);
                o_fifo_tx_write = !i_fifo_tx_full;
                if (!i_fifo_tx_full) state_n = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                // A byte present on the expiry cycle takes priority over the timeout.
                if (!i_fifo_rx_empty) begin
                    rx_read_raw = 1'b1;
                    take_res    = 1'b1;
                    state_n     = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // The state resets to IDLE, where a pop depends only on the FIFO flag.
    // Gating with the reset keeps the pop strobe low while reset is held.
    assign o_fifo_rx_read = rx_read_raw & i_reset;
    assign o_busy         = (state != ST_IDLE);
    assign o_done         = (state == ST_DONE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= '0;
            o_result  <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q    <= i_op_A;
                op_b_q    <= i_op_B;
                opcode_q  <= i_opcode;
                o_timeout <= 1'b0;
            end
            if (take_res) o_result  <= i_data_to_read;
            if (expire)   o_timeout <= 1'b1;
        end
    end

    // The counter is zero on the first WAIT_RES cycle and counts the cycles spent waiting.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else if (state != ST_WAIT_RES && state_n == ST_WAIT_RES) begin
            cnt_q <= '0;
        end else if (state == ST_WAIT_RES) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
